// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: FSM states, PC source
// selects and the branch-resolution helper.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;
  localparam logic [1:0] PC_SEL_REG = 2'd3;

  function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
    return (beq & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/mips_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear (clear wins
// over enable).
module mips_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks each instruction through
// IF/ID/EX/MEM/WB, drives datapath enables and keeps cycle/retire counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mem_ready,
  input  logic             i_go,
  input  logic             i_zero,
  input  logic             i_syscall_halt,
  input  logic             i_MemtoReg,
  input  logic             i_MemWrite,
  input  logic             i_RegWrite,
  input  logic             i_SYSCALL,
  input  logic             i_BEQ,
  input  logic             i_BNE,
  input  logic             i_JR,
  input  logic             i_JUMP,
  input  logic             i_JAL,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_iord,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic             o_reg_we,
  output logic             o_halted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_retired
);

  state_e     state_q, state_d;
  logic       ir_we, pc_we, mem_rd, mem_wr, reg_we, iord;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] cycles_cnt, retired_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_SEL_PC4;
    iord    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    reg_we  = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd = 1'b1;
        if (i_mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (i_SYSCALL) begin
          pc_we   = 1'b1;
          state_d = i_syscall_halt ? S_HALT : S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      // JR outranks JUMP/JAL, which outrank branches, then memory, then ALU writeback
      S_EX: begin
        if (i_JR) begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_REG;
          state_d = S_IF;
        end else if (i_JAL) begin
          state_d = S_WB;
        end else if (i_JUMP) begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_JMP;
          state_d = S_IF;
        end else if (i_BEQ | i_BNE) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken(i_BEQ, i_BNE, i_zero) ? PC_SEL_BR : PC_SEL_PC4;
          state_d = S_IF;
        end else if (i_MemtoReg | i_MemWrite) begin
          state_d = S_MEM;
        end else if (i_RegWrite) begin
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          state_d = S_IF;
        end
      end
      // a load wins if both memory flags are up, so read and write never overlap
      S_MEM: begin
        iord   = 1'b1;
        mem_rd = i_MemtoReg;
        mem_wr = i_MemWrite & ~i_MemtoReg;
        if (i_mem_ready) begin
          if (i_MemtoReg) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = i_JAL ? PC_SEL_JMP : PC_SEL_PC4;
        state_d = S_IF;
      end
      S_HALT: begin
        if (i_go) begin
          state_d = S_IF;
        end
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset masks everything combinationally so an aborted instruction writes nothing.
  assign o_ir_we   = i_rst_n & ir_we;
  assign o_pc_we   = i_rst_n & pc_we;
  assign o_pc_sel  = i_rst_n ? pc_sel : PC_SEL_PC4;
  assign o_iord    = i_rst_n & iord;
  assign o_mem_rd  = i_rst_n & mem_rd;
  assign o_mem_wr  = i_rst_n & mem_wr;
  assign o_reg_we  = i_rst_n & reg_we;
  assign o_halted  = i_rst_n & (state_q == S_HALT);
  assign o_state   = i_rst_n ? state_q : S_IF;
  assign o_cycles  = i_rst_n ? cycles_cnt : '0;
  assign o_retired = i_rst_n ? retired_cnt : '0;

  mips_perf_counter #(.CNT_W(CNT_W)) u_cycles (
    .i_clk   (i_clk),
    .i_clear (~i_rst_n),
    .i_en    (state_q != S_HALT),
    .o_count (cycles_cnt)
  );

  mips_perf_counter #(.CNT_W(CNT_W)) u_retired (
    .i_clk   (i_clk),
    .i_clear (~i_rst_n),
    .i_en    (o_pc_we),
    .o_count (retired_cnt)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level phase model with a
// per-cycle compare process, directed scenarios and randomized programs.
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;
  localparam int K_F = 0, K_D = 1, K_E = 2, K_M = 3, K_W = 4;

  typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_SYS, C_SYSX, C_NOP} cls_e;

  logic i_clk = 1'b0;
  logic i_rst_n, i_mem_ready, i_go, i_zero, i_syscall_halt;
  logic i_MemtoReg, i_MemWrite, i_RegWrite, i_SYSCALL, i_BEQ, i_BNE, i_JR, i_JUMP, i_JAL;
  logic o_ir_we, o_pc_we, o_iord, o_mem_rd, o_mem_wr, o_reg_we, o_halted;
  logic [1:0] o_pc_sel;
  logic [2:0] o_state;
  logic [CW-1:0] o_cycles, o_retired;

  always #5 i_clk = ~i_clk;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_ready(i_mem_ready), .i_go(i_go),
    .i_zero(i_zero), .i_syscall_halt(i_syscall_halt),
    .i_MemtoReg(i_MemtoReg), .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite),
    .i_SYSCALL(i_SYSCALL), .i_BEQ(i_BEQ), .i_BNE(i_BNE), .i_JR(i_JR),
    .i_JUMP(i_JUMP), .i_JAL(i_JAL),
    .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_iord(o_iord),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_reg_we(o_reg_we),
    .o_halted(o_halted), .o_state(o_state), .o_cycles(o_cycles), .o_retired(o_retired)
  );

  int n_checks = 0;
  int n_err = 0;
  cls_e cur = C_NOP;
  bit xtra = 1'b0;
  int zero_mode = 2;
  int stepq[$];
  bit script[$];
  bit m_halted = 1'b0;
  logic [CW-1:0] m_cycles = '0, m_retired = '0;
  bit chk_en = 1'b0;

  logic e_ir_we, e_pc_we, e_mem_rd, e_mem_wr, e_reg_we, e_iord, e_halted;
  logic [1:0] e_pc_sel;
  logic [2:0] e_state;
  logic [CW-1:0] e_cycles, e_retired;

  logic s_pc_we, s_mem_rd, s_mem_wr, s_reg_we, s_iord, s_ir_we, s_halted;
  logic [1:0] s_pc_sel;
  logic [2:0] s_state;

  int hist_n;
  logic [2:0] h_state [64];
  logic [1:0] h_sel [64];
  logic h_reg_we [64];
  logic h_pc_we [64];
  logic h_mem_rd [64];
  logic h_mem_wr [64];
  logic h_iord [64];
  logic h_ir_we [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("ir_we",   32'(o_ir_we),   32'(e_ir_we));
      chk("pc_we",   32'(o_pc_we),   32'(e_pc_we));
      chk("pc_sel",  32'(o_pc_sel),  32'(e_pc_sel));
      chk("iord",    32'(o_iord),    32'(e_iord));
      chk("mem_rd",  32'(o_mem_rd),  32'(e_mem_rd));
      chk("mem_wr",  32'(o_mem_wr),  32'(e_mem_wr));
      chk("reg_we",  32'(o_reg_we),  32'(e_reg_we));
      chk("halted",  32'(o_halted),  32'(e_halted));
      chk("state",   32'(o_state),   32'(e_state));
      chk("cycles",  32'(o_cycles),  32'(e_cycles));
      chk("retired", 32'(o_retired), 32'(e_retired));
    end
  end

  task automatic set_flags(input cls_e c);
    {i_MemtoReg, i_MemWrite, i_RegWrite, i_SYSCALL, i_BEQ, i_BNE, i_JR, i_JUMP, i_JAL} = 9'b0;
    case (c)
      C_R:  i_RegWrite = 1'b1;
      C_LW: begin i_MemtoReg = 1'b1; i_RegWrite = 1'b1; end
      C_SW: i_MemWrite = 1'b1;
      C_BEQ: i_BEQ = 1'b1;
      C_BNE: i_BNE = 1'b1;
      C_J:  i_JUMP = 1'b1;
      C_JR: begin i_JR = 1'b1; i_JUMP = xtra; end
      C_JAL: begin i_JAL = 1'b1; i_JUMP = xtra; i_RegWrite = 1'b1; end
      C_SYS, C_SYSX: i_SYSCALL = 1'b1;
      default: ;
    endcase
  endtask

  // Phase list an instruction class walks through.
  function automatic void build(input cls_e c);
    stepq.delete();
    stepq.push_back(K_F);
    stepq.push_back(K_D);
    if (c == C_SYS || c == C_SYSX) return;
    stepq.push_back(K_E);
    case (c)
      C_LW: begin stepq.push_back(K_M); stepq.push_back(K_W); end
      C_SW: stepq.push_back(K_M);
      C_R, C_JAL: stepq.push_back(K_W);
      default: ;
    endcase
  endfunction

  task automatic do_cycle(input bit rdy, input bit go, input bit rstn);
    int k;
    logic zr;
    k = -1;
    i_rst_n = rstn;
    i_mem_ready = rdy;
    i_go = go;
    zr = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    i_zero = zr;
    set_flags(cur);
    i_syscall_halt = (cur == C_SYS) ? 1'b0 : (cur == C_SYSX) ? 1'b1 : 1'($urandom_range(0, 1));

    {e_ir_we, e_pc_we, e_mem_rd, e_mem_wr, e_reg_we, e_iord, e_halted} = 7'b0;
    e_pc_sel = 2'd0;
    e_state = 3'd0;
    e_cycles = m_cycles;
    e_retired = m_retired;
    if (!rstn) begin
      e_cycles = '0;
      e_retired = '0;
    end else if (m_halted) begin
      e_state = 3'd5;
      e_halted = 1'b1;
    end else begin
      k = stepq[0];
      e_state = 3'(k);
      case (k)
        K_F: begin e_mem_rd = 1'b1; e_ir_we = rdy; end
        K_D: e_pc_we = (cur == C_SYS || cur == C_SYSX);
        K_E: begin
          case (cur)
            C_JR:  begin e_pc_we = 1'b1; e_pc_sel = 2'd3; end
            C_J:   begin e_pc_we = 1'b1; e_pc_sel = 2'd2; end
            C_BEQ: begin e_pc_we = 1'b1; e_pc_sel = zr ? 2'd1 : 2'd0; end
            C_BNE: begin e_pc_we = 1'b1; e_pc_sel = zr ? 2'd0 : 2'd1; end
            C_NOP: e_pc_we = 1'b1;
            default: ;
          endcase
        end
        K_M: begin
          e_iord = 1'b1;
          e_mem_rd = (cur == C_LW);
          e_mem_wr = (cur == C_SW);
          e_pc_we = rdy && (cur == C_SW);
        end
        K_W: begin
          e_reg_we = 1'b1;
          e_pc_we = 1'b1;
          e_pc_sel = (cur == C_JAL) ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
    chk_en = 1'b1;

    @(negedge i_clk);
    s_pc_we = o_pc_we; s_mem_rd = o_mem_rd; s_mem_wr = o_mem_wr; s_reg_we = o_reg_we;
    s_iord = o_iord; s_ir_we = o_ir_we; s_halted = o_halted; s_pc_sel = o_pc_sel;
    s_state = o_state;
    @(posedge i_clk);
    #1;

    if (!rstn) begin
      stepq.delete();
      m_cycles = '0;
      m_retired = '0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      if (go) m_halted = 1'b0;
    end else begin
      m_cycles = m_cycles + 1'b1;
      if (e_pc_we) m_retired = m_retired + 1'b1;
      if (!((k == K_F || k == K_M) && !rdy)) begin
        void'(stepq.pop_front());
        if (k == K_D && cur == C_SYSX) m_halted = 1'b1;
      end
    end
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready taken from script
  task automatic run_instr(input cls_e c, input int rmode);
    bit r;
    cur = c;
    build(c);
    hist_n = 0;
    while (stepq.size() > 0 && !m_halted) begin
      if (hist_n >= 40) begin
        n_checks++;
        n_err++;
        $display("FAIL timeout: instruction %0d did not complete in %0d cycles", c, hist_n);
        stepq.delete();
        break;
      end
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) r = ($urandom_range(0, 9) < 7);
      else r = (script.size() > 0) ? script.pop_front() : 1'b1;
      do_cycle(r, 1'b0, 1'b1);
      hist_n++;
      h_state[hist_n] = s_state; h_sel[hist_n] = s_pc_sel; h_reg_we[hist_n] = s_reg_we;
      h_pc_we[hist_n] = s_pc_we; h_mem_rd[hist_n] = s_mem_rd; h_mem_wr[hist_n] = s_mem_wr;
      h_iord[hist_n] = s_iord; h_ir_we[hist_n] = s_ir_we;
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_mem_ready = 1'b0; i_go = 1'b0; i_zero = 1'b0; i_syscall_halt = 1'b0;
    set_flags(C_NOP);

    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_cycles", 32'(o_cycles), 32'd0);

    run_instr(C_R, 0);
    chk("add_len", 32'(hist_n), 32'd4);
    chk("add_states", {8'(h_state[1]), 8'(h_state[2]), 8'(h_state[3]), 8'(h_state[4])}, 32'h00010204);
    chk("add_reg_we_c4", 32'(h_reg_we[4]), 32'd1);
    chk("add_retired", 32'(o_retired), 32'd1);

    script = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_instr(C_LW, 2);
    chk("lw_len", 32'(hist_n), 32'd10);
    chk("lw_reg_we_c10", 32'(h_reg_we[10]), 32'd1);
    chk("lw_if_wait", {8'(h_mem_rd[1]), 8'(h_mem_rd[3]), 8'(h_ir_we[3]), 8'(h_iord[3])}, 32'h01010000);
    chk("lw_mem_wait", {8'(h_mem_rd[7]), 8'(h_iord[7]), 8'(h_mem_wr[7]), 8'(h_reg_we[9])}, 32'h01010000);

    zero_mode = 1;
    run_instr(C_BEQ, 0);
    chk("beq_z1", {8'(h_pc_we[3]), 8'(h_sel[3]), 8'(h_reg_we[3])}, 32'h00010100);
    chk("cycles_wrap", 32'(o_cycles), 32'd1);
    chk("retired_3", 32'(o_retired), 32'd3);
    zero_mode = 0;
    run_instr(C_BEQ, 0);
    chk("beq_z0", {8'(h_pc_we[3]), 8'(h_sel[3])}, 32'h0100);
    run_instr(C_BNE, 0);
    chk("bne_z0", 32'(h_sel[3]), 32'd1);
    zero_mode = 1;
    run_instr(C_BNE, 0);
    chk("bne_z1", 32'(h_sel[3]), 32'd0);
    zero_mode = 2;

    xtra = 1'b1;
    run_instr(C_JR, 0);
    chk("jr_jump_sel", 32'(h_sel[3]), 32'd3);
    run_instr(C_JAL, 0);
    chk("jal", {8'(hist_n), 8'(h_reg_we[4]), 8'(h_sel[4]), 8'(h_pc_we[4])}, 32'h04010201);
    xtra = 1'b0;
    run_instr(C_SW, 0);
    chk("sw", {8'(hist_n), 8'(h_mem_wr[4]), 8'(h_iord[4]), 8'(h_pc_we[4])}, 32'h04010101);

    run_instr(C_SYSX, 0);
    chk("sysx_len", 32'(hist_n), 32'd2);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b1);
    chk("halt_idle", {8'(s_halted), 8'(s_state)}, 32'h0105);
    do_cycle(1'b1, 1'b1, 1'b1);
    run_instr(C_R, 0);
    chk("go_to_if", 32'(h_state[1]), 32'd0);

    cur = C_SW;
    build(C_SW);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b0);
    chk("rst_in_mem", {8'(s_mem_wr), 8'(s_pc_we), 8'(s_state), 8'(s_iord)}, 32'h00000000);

    for (int n = 0; n < 300; n++) begin
      xtra = 1'($urandom_range(0, 1));
      run_instr(cls_e'($urandom_range(0, 10)), 1);
      if (m_halted) begin
        for (int i = 0; i < int'($urandom_range(1, 5)); i++) do_cycle(1'b1, 1'b0, 1'b1);
        if ($urandom_range(0, 3) == 0) do_cycle(1'b1, 1'b1, 1'b0);
        else do_cycle(1'b1, 1'b1, 1'b1);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
